h14tx_period_sched: RTL and testbench

//  Per-character period scheduler for the HDMI 1.4 TX. Sequences control, video preamble/guard and

---
 rtl/h14tx_pkg.sv | 34 +++
 rtl/h14tx_delay_line.sv | 27 ++
 rtl/h14tx_period_sched.sv | 202 ++++++++++++++++++++
 tb/tb_h14tx_period_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/h14tx_pkg.sv
// Shared types and constants for the HDMI 1.4 TX period scheduler.
// Ports: none (package). Provides period_t, ctl_t, period lengths, preamble CTL codes
// and a helper that classifies data-island periods.
package h14tx_pkg;

  typedef enum logic [2:0] {
    PER_CTL,
    PER_VID_PRE,
    PER_VID_GB,
    PER_VIDEO,
    PER_ISL_PRE,
    PER_ISL_GB_LEAD,
    PER_ISL_DATA,
    PER_ISL_GB_TRAIL
  } period_t;

  typedef logic [1:0] ctl_t;

  localparam int PREAMBLE_LEN = 8;
  localparam int GB_LEN       = 2;
  localparam int PKT_LEN      = 32;
  localparam int LOOKAHEAD    = 10;

  localparam ctl_t CTL_VID_PRE1 = 2'b01;
  localparam ctl_t CTL_VID_PRE2 = 2'b00;
  localparam ctl_t CTL_ISL_PRE1 = 2'b01;
  localparam ctl_t CTL_ISL_PRE2 = 2'b01;

  function automatic logic is_island(input period_t p);
    return (p == PER_ISL_PRE) || (p == PER_ISL_GB_LEAD) ||
           (p == PER_ISL_DATA) || (p == PER_ISL_GB_TRAIL);
  endfunction

endpackage

// File: rtl/h14tx_delay_line.sv
// Fixed-depth shift register with synchronous active-high clear.
// Ports: clk, rst (sync, active-high), dat_i (WIDTH bits in), dat_o (dat_i delayed DEPTH cycles).
// Latency DEPTH cycles; no flow control, advances every clock.
module h14tx_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dat_i,
  output logic [WIDTH-1:0] dat_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= dat_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dat_o = stage_q[DEPTH-1];

endmodule

// File: rtl/h14tx_period_sched.sv
// Per-character period scheduler for the HDMI 1.4 TX: sequences control, video preamble/guard
// and data-island periods and drives the per-channel CTL codes and the channel mode select.
// Ports: clk/rst (sync, active-high); de_i/hsync_i/vsync_i undelayed timing; blank_remain budget;
// pkt_valid/pkt_ready/pkt_idx packet handshake; period, ctl0..ctl2 encoder controls;
// de_o/hsync_o/vsync_o delayed timing; err pulse when video truncates an island.
module h14tx_period_sched
  import h14tx_pkg::*;
#(
  parameter int MAX_PKTS     = 18,
  parameter int MIN_CTL_LEAD = 4,
  parameter int MIN_CTL_TAIL = 4,
  parameter int BUDGET_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                de_i,
  input  logic                hsync_i,
  input  logic                vsync_i,
  input  logic [BUDGET_W-1:0] blank_remain,
  input  logic                pkt_valid,
  output logic                pkt_ready,
  output logic [4:0]          pkt_idx,
  output period_t             period,
  output ctl_t                ctl0,
  output ctl_t                ctl1,
  output ctl_t                ctl2,
  output logic                de_o,
  output logic                hsync_o,
  output logic                vsync_o,
  output logic                err
);

  localparam int                  RUN_W      = $clog2(MIN_CTL_LEAD + 2);
  localparam logic [RUN_W-1:0]    RUN_SAT    = RUN_W'(MIN_CTL_LEAD);
  // Island start must fit preamble, lead guard, one packet, trailing guard and the tail gap.
  localparam logic [BUDGET_W-1:0] ISL_BUDGET =
    BUDGET_W'(PREAMBLE_LEN + GB_LEN + PKT_LEN + GB_LEN + MIN_CTL_TAIL);
  // Another packet must fit itself, the trailing guard and the tail gap.
  localparam logic [BUDGET_W-1:0] PKT_BUDGET = BUDGET_W'(PKT_LEN + GB_LEN + MIN_CTL_TAIL);
  localparam logic [4:0]          PKT_LAST   = 5'(PKT_LEN - 1);
  localparam logic [4:0]          MAX_PKTS_C = 5'(MAX_PKTS);
  localparam logic [2:0]          PRE_LAST   = 3'(PREAMBLE_LEN - 1);
  localparam logic [2:0]          GB_LAST    = 3'(GB_LEN - 1);

  period_t          state_q, state_d;
  logic [2:0]       len_q, len_d;      // cycles left in a timed period, 0 = last
  logic [4:0]       idx_q, idx_d;
  logic [4:0]       npkt_q, npkt_d;
  logic [RUN_W-1:0] ctl_run_q, ctl_run_d;
  logic             de_prev_q;
  logic             err_q, err_d;
  logic [2:0]       dly_out;
  logic [2:0]       out_q;             // {vsync, hsync, de} after the delay line

  logic de_rise, in_island, len_last, isl_ok, pkt_ok;

  // The FSM answers one register after sampling de_i, so the syncs get the same output
  // register after LOOKAHEAD stages; de_o then rises exactly when period enters PER_VIDEO.
  h14tx_delay_line #(
    .WIDTH (3),
    .DEPTH (LOOKAHEAD)
  ) u_dly (
    .clk   (clk),
    .rst   (rst),
    .dat_i ({vsync_i, hsync_i, de_i}),
    .dat_o (dly_out)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PER_CTL;
      len_q     <= '0;
      idx_q     <= '0;
      npkt_q    <= '0;
      ctl_run_q <= '0;
      de_prev_q <= 1'b0;
      err_q     <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      npkt_q    <= npkt_d;
      ctl_run_q <= ctl_run_d;
      de_prev_q <= de_i;
      err_q     <= err_d;
      out_q     <= dly_out;
    end
  end

  // Next-state logic
  always_comb begin
    de_rise   = de_i & ~de_prev_q;
    in_island = is_island(state_q);
    len_last  = (len_q == 3'd0);
    // blank_remain is only meaningful while de_i is low.
    isl_ok    = pkt_valid & ~de_i & (ctl_run_q >= RUN_SAT) & (blank_remain >= ISL_BUDGET);
    pkt_ok    = pkt_valid & ~de_i & (npkt_q < MAX_PKTS_C) & (blank_remain >= PKT_BUDGET);

    state_d   = state_q;
    len_d     = len_q;
    idx_d     = 5'd0;
    npkt_d    = npkt_q;
    err_d     = 1'b0;
    ctl_run_d = (state_q == PER_CTL) ? ((ctl_run_q == RUN_SAT) ? ctl_run_q : ctl_run_q + 1'b1)
                                     : '0;

    if (de_rise && ((state_q == PER_CTL) || in_island)) begin
      // Video always wins; an island in flight is cut without its trailing guard.
      state_d = PER_VID_PRE;
      len_d   = PRE_LAST;
      npkt_d  = 5'd0;
      err_d   = in_island;
    end else begin
      case (state_q)
        PER_CTL: begin
          if (isl_ok) begin
            state_d = PER_ISL_PRE;
            len_d   = PRE_LAST;
            npkt_d  = 5'd0;
          end
        end
        PER_VID_PRE: begin
          if (len_last) begin
            state_d = PER_VID_GB;
            len_d   = GB_LAST;
          end else begin
            len_d = len_q - 3'd1;
          end
        end
        PER_VID_GB: begin
          if (len_last) state_d = PER_VIDEO;
          else          len_d   = len_q - 3'd1;
        end
        PER_VIDEO: begin
          // dly_out is what de_o shows next cycle.
          if (!dly_out[0]) state_d = PER_CTL;
        end
        PER_ISL_PRE: begin
          if (len_last) begin
            state_d = PER_ISL_GB_LEAD;
            len_d   = GB_LAST;
          end else begin
            len_d = len_q - 3'd1;
          end
        end
        PER_ISL_GB_LEAD: begin
          if (len_last) begin
            state_d = PER_ISL_DATA;
            npkt_d  = 5'd1;
          end else begin
            len_d = len_q - 3'd1;
          end
        end
        PER_ISL_DATA: begin
          if (idx_q == PKT_LAST) begin
            if (pkt_ok) begin
              npkt_d = npkt_q + 5'd1;
            end else begin
              state_d = PER_ISL_GB_TRAIL;
              len_d   = GB_LAST;
            end
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
        PER_ISL_GB_TRAIL: begin
          if (len_last) state_d = PER_CTL;
          else          len_d   = len_q - 3'd1;
        end
        default: state_d = PER_CTL;
      endcase
    end
  end

  // Output logic (all terms come straight from registers)
  always_comb begin
    ctl1 = 2'b00;
    ctl2 = 2'b00;
    case (state_q)
      PER_VID_PRE: begin
        ctl1 = CTL_VID_PRE1;
        ctl2 = CTL_VID_PRE2;
      end
      PER_ISL_PRE: begin
        ctl1 = CTL_ISL_PRE1;
        ctl2 = CTL_ISL_PRE2;
      end
      default: ;
    endcase
    period    = state_q;
    pkt_idx   = idx_q;
    pkt_ready = (state_q == PER_ISL_DATA) && (idx_q == 5'd0);
    err       = err_q;
    de_o      = out_q[0];
    hsync_o   = out_q[1];
    vsync_o   = out_q[2];
    ctl0      = {out_q[2], out_q[1]};
  end

endmodule

// File: tb/tb_h14tx_period_sched.sv
module tb_h14tx_period_sched;
  import h14tx_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        de_i = 1'b0, hsync_i = 1'b0, vsync_i = 1'b0, pkt_valid = 1'b0;
  logic [15:0] blank_remain = 16'd0;
  logic        pkt_ready, de_o, hsync_o, vsync_o, err;
  logic [4:0]  pkt_idx;
  period_t     period;
  ctl_t        ctl0, ctl1, ctl2;

  always #5 clk = ~clk;

  h14tx_period_sched dut (
    .clk(clk), .rst(rst), .de_i(de_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .blank_remain(blank_remain), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_idx(pkt_idx), .period(period), .ctl0(ctl0), .ctl1(ctl1), .ctl2(ctl2),
    .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of upcoming periods planned from the rules, plus
  // a plain history queue for the LOOKAHEAD delay of de/hsync/vsync.
  period_t    plan[$];
  logic [2:0] hist[$];
  period_t    m_per;
  int         m_run, m_npkt;
  logic       m_prev_de, m_err, m_rdy;
  logic [4:0] m_idx;
  logic [2:0] m_dly;

  task automatic model_step(input logic r, input logic d, input logic hs, input logic vs,
                            input logic [15:0] br, input logic pv);
    period_t cur;
    logic    rise, cur_isl;
    int      new_run, ndata;
    if (r) begin
      m_per = PER_CTL; plan.delete(); hist.delete();
      repeat (10) hist.push_back(3'b000);
      m_run = 0; m_npkt = 0; m_prev_de = 1'b0; m_err = 1'b0; m_rdy = 1'b0;
      m_idx = 5'd0; m_dly = 3'b000;
      return;
    end
    hist.push_back({vs, hs, d});
    m_dly     = hist.pop_front();
    cur       = m_per;
    cur_isl   = cur inside {PER_ISL_PRE, PER_ISL_GB_LEAD, PER_ISL_DATA, PER_ISL_GB_TRAIL};
    rise      = d & ~m_prev_de;
    m_prev_de = d;
    new_run   = (cur == PER_CTL) ? m_run + 1 : 0;
    m_err     = 1'b0;
    if (rise && (cur == PER_CTL || cur_isl)) begin
      m_err = cur_isl;
      plan.delete();
      repeat (8) plan.push_back(PER_VID_PRE);
      repeat (2) plan.push_back(PER_VID_GB);
      m_npkt = 0;
    end else if (plan.size() == 0) begin
      case (cur)
        PER_CTL:
          if (pv && !d && m_run >= 4 && br >= 16'd48) begin
            repeat (8)  plan.push_back(PER_ISL_PRE);
            repeat (2)  plan.push_back(PER_ISL_GB_LEAD);
            repeat (32) plan.push_back(PER_ISL_DATA);
            m_npkt = 1;
          end
        PER_VID_GB: plan.push_back(PER_VIDEO);
        PER_VIDEO:  if (m_dly[0]) plan.push_back(PER_VIDEO);
        PER_ISL_DATA:
          if (pv && !d && m_npkt < 18 && br >= 16'd38) begin
            repeat (32) plan.push_back(PER_ISL_DATA);
            m_npkt++;
          end else begin
            repeat (2) plan.push_back(PER_ISL_GB_TRAIL);
          end
        default: ;
      endcase
    end
    m_per = (plan.size() != 0) ? plan.pop_front() : PER_CTL;
    m_run = new_run;
    ndata = 0;
    foreach (plan[i]) if (plan[i] == PER_ISL_DATA) ndata++;
    m_idx = (m_per == PER_ISL_DATA) ? 5'(31 - ndata) : 5'd0;
    m_rdy = (m_per == PER_ISL_DATA) && (m_idx == 5'd0);
  endtask

  // Observations of the DUT used by scenario-level checks.
  int      rdy_total = 0, isl_cur = 0, isl_max = 0, obs_ctl = 0, min_gap = 1000000;
  period_t prev_obs = PER_CTL;

  task automatic tick(input logic r, input logic d, input int unsigned br, input logic pv);
    logic hs, vs;
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    rst = r; de_i = d; hsync_i = hs; vsync_i = vs; blank_remain = br[15:0]; pkt_valid = pv;
    model_step(r, d, hs, vs, br[15:0], pv);
    @(negedge clk);
    chk("period",    period,    m_per);
    chk("ctl1",      ctl1,      (m_per == PER_VID_PRE || m_per == PER_ISL_PRE) ? 2'b01 : 2'b00);
    chk("ctl2",      ctl2,      (m_per == PER_ISL_PRE) ? 2'b01 : 2'b00);
    chk("pkt_ready", pkt_ready, m_rdy);
    chk("pkt_idx",   pkt_idx,   m_idx);
    chk("err",       err,       m_err);
    chk("de_o",      de_o,      m_dly[0]);
    chk("syncs",     {vsync_o, hsync_o}, m_dly[2:1]);
    chk("ctl0",      ctl0,      m_dly[2:1]);
    if (period == PER_ISL_PRE && prev_obs != PER_ISL_PRE) begin
      if (obs_ctl < min_gap) min_gap = obs_ctl;
      isl_cur = 0;
    end
    obs_ctl = (period == PER_CTL) ? obs_ctl + 1 : 0;
    if (pkt_ready === 1'b1) begin
      rdy_total++;
      isl_cur++;
      if (isl_cur > isl_max) isl_max = isl_cur;
    end
    prev_obs = period;
  endtask

  // pv_from < 0: random pkt_valid; otherwise pkt_valid once blank_remain <= pv_from.
  task automatic blank(input int len, input int pv_from, input bit unlim);
    for (int k = 0; k < len; k++) begin
      int unsigned br;
      logic        pv;
      br = unlim ? 32'hFFFF : 32'(len - k);
      pv = (pv_from < 0) ? 1'($urandom_range(0, 1)) : ((len - k) <= pv_from);
      tick(1'b0, 1'b0, br, pv);
    end
  endtask

  task automatic active(input int len, input bit chk_vid);
    for (int i = 0; i < len; i++) begin
      tick(1'b0, 1'b1, $urandom_range(0, 65535), 1'($urandom_range(0, 1)));
      if (chk_vid) begin
        if (i == 0)  chk("vid_pre_first", period, PER_VID_PRE);
        if (i == 7)  chk("vid_pre_last_ctl1", ctl1, 2'b01);
        if (i == 8)  chk("vid_gb_first", period, PER_VID_GB);
        if (i == 9)  chk("vid_gb_de_o_low", de_o, 1'b0);
        if (i == 10) chk("video_first", period, PER_VIDEO);
        if (i == 10) chk("video_de_o_high", de_o, 1'b1);
      end
    end
  endtask

  initial begin
    int  r0;
    bit  found;
    @(negedge clk);
    repeat (3) tick(1'b1, 1'b0, 0, 1'b0);
    chk("rst_period", period, PER_CTL);
    chk("rst_pkt_idx", pkt_idx, 5'd0);
    chk("rst_de_o", de_o, 1'b0);

    // Video after 20 blank cycles, no packets.
    blank(20, 0, 1'b0);
    active(40, 1'b1);

    // Budget boundary: pkt_valid first seen at blank_remain 47 / 48 / 100.
    r0 = rdy_total; blank(150, 47, 1'b0);
    chk("budget47_pkts", rdy_total - r0, 0);
    active(20, 1'b0);
    r0 = rdy_total; blank(150, 48, 1'b0);
    chk("budget48_pkts", rdy_total - r0, 1);
    active(20, 1'b0);
    r0 = rdy_total; blank(150, 100, 1'b0);
    chk("budget100_pkts", rdy_total - r0, 2);
    active(20, 1'b0);

    // Unlimited budget: packet cap per island.
    isl_max = 0;
    blank(1400, 100000, 1'b1);
    chk("isl_max_pkts", isl_max, 18);
    active(30, 1'b0);

    // Video rising in the middle of a packet.
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      tick(1'b0, 1'b0, 32'hFFFF, 1'b1);
      if (period == PER_ISL_DATA && pkt_idx == 5'd5) found = 1'b1;
    end
    chk("trunc_reached", found, 1'b1);
    r0 = rdy_total;
    tick(1'b0, 1'b1, 0, 1'b1);
    chk("trunc_err", err, 1'b1);
    chk("trunc_vid_pre", period, PER_VID_PRE);
    active(29, 1'b0);
    chk("trunc_no_rdy", rdy_total - r0, 0);

    // Reset in the middle of a packet.
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      tick(1'b0, 1'b0, 32'hFFFF, 1'b1);
      if (period == PER_ISL_DATA && pkt_idx == 5'd12) found = 1'b1;
    end
    chk("rst_mid_reached", found, 1'b1);
    tick(1'b1, 1'b0, 32'hFFFF, 1'b1);
    chk("rst_mid_period", period, PER_CTL);
    chk("rst_mid_rdy", pkt_ready, 1'b0);
    chk("rst_mid_de_o", de_o, 1'b0);
    chk("rst_mid_ctl12", {ctl1, ctl2}, 4'b0000);
    blank(60, 100000, 1'b1);
    active(25, 1'b0);

    // Randomized frames within contract.
    for (int f = 0; f < 16; f++) begin
      int pvm;
      pvm = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 160));
      blank(int'($urandom_range(12, 150)), pvm, 1'b0);
      active(int'($urandom_range(4, 60)), 1'b0);
    end
    blank(20, 0, 1'b0);

    chk("isl_lead_gap_ge4", (min_gap >= 4), 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
